// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 16-bit RISC control unit.
// Holds opcode constants, the 3-bit FSM state encoding, instruction
// register field positions, the ALU select width and an opcode classifier.
package cpu_pkg;

  localparam int INSTR_W  = 16;
  localparam int ALU_OP_W = 4;

  // Instruction fields: [15:9] opcode, [8:6] W, [5:3] R, [2:0] S
  localparam int IR_OPC_MSB = 15;
  localparam int IR_OPC_LSB = 9;
  localparam int IR_W_MSB   = 8;
  localparam int IR_W_LSB   = 6;
  localparam int IR_R_MSB   = 5;
  localparam int IR_R_LSB   = 3;
  localparam int IR_S_MSB   = 2;
  localparam int IR_S_LSB   = 0;

  localparam logic [6:0] OPC_NOP  = 7'h00;
  localparam logic [6:0] OPC_ADD  = 7'h01;
  localparam logic [6:0] OPC_SUB  = 7'h02;
  localparam logic [6:0] OPC_AND  = 7'h03;
  localparam logic [6:0] OPC_OR   = 7'h04;
  localparam logic [6:0] OPC_XOR  = 7'h05;
  localparam logic [6:0] OPC_NOT  = 7'h06;
  localparam logic [6:0] OPC_MOV  = 7'h07;
  localparam logic [6:0] OPC_INC  = 7'h08;
  localparam logic [6:0] OPC_DEC  = 7'h09;
  localparam logic [6:0] OPC_HALT = 7'h7F;

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_HALT    = 3'd4
  } state_e;

  // True for opcodes that go through EXECUTE and write a register.
  function automatic logic is_alu_op(input logic [6:0] opc);
    case (opc)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR,
      OPC_NOT, OPC_MOV, OPC_INC, OPC_DEC: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_control_unit_if.sv
// cpu_control_unit_if: bundle between the control unit and the datapath.
//   instr            instruction word at current PC (datapath -> control)
//   alu_n/z/c        ALU status for the current operation
//   pc_inc, ir_ld    fetch strobes
//   w_en, w_adr      register write enable / select (feeds 3-to-8 decoder)
//   r_adr, s_adr     read port addresses
//   alu_op           ALU function select
//   flags            latched {N,Z,C}
//   halted, illegal  halt status
// master = control unit side, slave = datapath side.
interface cpu_control_unit_if;
  import cpu_pkg::*;

  logic [INSTR_W-1:0]  instr;
  logic                alu_n;
  logic                alu_z;
  logic                alu_c;
  logic                pc_inc;
  logic                ir_ld;
  logic                w_en;
  logic [2:0]          w_adr;
  logic [2:0]          r_adr;
  logic [2:0]          s_adr;
  logic [ALU_OP_W-1:0] alu_op;
  logic [2:0]          flags;
  logic                halted;
  logic                illegal;

  modport master (
    input  instr, alu_n, alu_z, alu_c,
    output pc_inc, ir_ld, w_en, w_adr, r_adr, s_adr, alu_op, flags,
           halted, illegal
  );

  modport slave (
    output instr, alu_n, alu_z, alu_c,
    input  pc_inc, ir_ld, w_en, w_adr, r_adr, s_adr, alu_op, flags,
           halted, illegal
  );

endinterface

// File: rtl/cpu_control_unit_ir_reg16.sv
// ir_reg16: 16-bit load-enable register with asynchronous active-high
// reset, used as the instruction register.
//   clk, reset  clock / async reset
//   ld_i        load strobe
//   d_i         data in
//   q_o         registered data out
module ir_reg16
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               ld_i,
  input  logic [INSTR_W-1:0] d_i,
  output logic [INSTR_W-1:0] q_o
);

  logic [INSTR_W-1:0] data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else if (ld_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle FETCH/DECODE/EXECUTE sequencer.
//   clk, reset  clock / asynchronous active-high reset
//   bus         cpu_control_unit_if.master (instr and ALU status in;
//               strobes, register addresses, alu_op, flags, halt status out)
// All outputs are Moore: decoded from the state register, IR, flags and
// the illegal latch only, so an asynchronous reset drops them at once.
module cpu_control_unit
  import cpu_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  cpu_control_unit_if.master     bus
);

  state_e             state_q;
  logic [2:0]         flags_q;
  logic               illegal_q;
  logic [INSTR_W-1:0] ir_q;
  logic [6:0]         opc;
  logic               ir_ld;
  logic               in_reset;

  assign ir_ld    = (state_q == ST_FETCH);
  assign in_reset = (state_q == ST_RESET);
  assign opc      = ir_q[IR_OPC_MSB:IR_OPC_LSB];

  ir_reg16 u_ir (
    .clk   (clk),
    .reset (reset),
    .ld_i  (ir_ld),
    .d_i   (bus.instr),
    .q_o   (ir_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_RESET;
      flags_q   <= 3'b000;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RESET: state_q <= ST_FETCH;
        ST_FETCH: state_q <= ST_DECODE;
        ST_DECODE: begin
          if (opc == OPC_HALT) begin
            state_q <= ST_HALT;
          end else if (opc == OPC_NOP) begin
            state_q <= ST_FETCH;
          end else if (is_alu_op(opc)) begin
            state_q <= ST_EXECUTE;
          end else begin
            // Undefined opcode: stop and remember why.
            state_q   <= ST_HALT;
            illegal_q <= 1'b1;
          end
        end
        ST_EXECUTE: begin
          flags_q <= {bus.alu_n, bus.alu_z, bus.alu_c};
          state_q <= ST_FETCH;
        end
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_RESET;
      endcase
    end
  end

  assign bus.pc_inc  = ir_ld;
  assign bus.ir_ld   = ir_ld;
  assign bus.w_en    = (state_q == ST_EXECUTE);
  assign bus.w_adr   = in_reset ? 3'd0 : ir_q[IR_W_MSB:IR_W_LSB];
  assign bus.r_adr   = in_reset ? 3'd0 : ir_q[IR_R_MSB:IR_R_LSB];
  assign bus.s_adr   = in_reset ? 3'd0 : ir_q[IR_S_MSB:IR_S_LSB];
  // EXECUTE is only entered for opcodes 01-09, so the low nibble is the select.
  assign bus.alu_op  = (state_q == ST_EXECUTE) ? opc[ALU_OP_W-1:0] : '0;
  assign bus.flags   = flags_q;
  assign bus.halted  = (state_q == ST_HALT);
  assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
module tb_cpu_control_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    logic [2:0] w;
    logic [2:0] r;
    logic [2:0] s;
    logic [3:0] op;
  } wb_t;

  wb_t exp_q[$];
  logic prev_wen = 1'b0;

  cpu_control_unit_if bus();

  cpu_control_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Snapshot of every output, MSB first:
  // pc_inc ir_ld w_en w_adr r_adr s_adr alu_op flags halted illegal
  function automatic logic [20:0] outs();
    return {bus.pc_inc, bus.ir_ld, bus.w_en, bus.w_adr, bus.r_adr, bus.s_adr,
            bus.alu_op, bus.flags, bus.halted, bus.illegal};
  endfunction

  // Write-back monitor: every w_en pulse must match the next expected entry.
  always @(negedge clk) begin
    if (bus.w_en === 1'b1) begin
      checks++;
      if (prev_wen) begin
        errors++;
        $display("FAIL wen_consecutive: actual=w_en high two cycles required=single pulse");
      end
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: actual=w_adr %0d required=no write", bus.w_adr);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        if ({bus.w_adr, bus.r_adr, bus.s_adr, bus.alu_op} !== {e.w, e.r, e.s, e.op}) begin
          errors++;
          $display("FAIL wb_fields: actual=w%0d r%0d s%0d op%0d required=w%0d r%0d s%0d op%0d",
                   bus.w_adr, bus.r_adr, bus.s_adr, bus.alu_op, e.w, e.r, e.s, e.op);
        end else begin
          $display("wb w_adr=%0d r_adr=%0d s_adr=%0d alu_op=%0d ok",
                   bus.w_adr, bus.r_adr, bus.s_adr, bus.alu_op);
        end
      end
    end
    prev_wen = (bus.w_en === 1'b1);
  end

  initial begin
    #100000;
    $display("FAIL timeout: actual=still running required=finished");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mk(input logic [6:0] opc, input logic [2:0] w,
                                      input logic [2:0] r, input logic [2:0] s);
    return {opc, w, r, s};
  endfunction

  function automatic wb_t mkwb(input logic [2:0] w, input logic [2:0] r,
                               input logic [2:0] s, input logic [3:0] op);
    wb_t e;
    e.w = w; e.r = r; e.s = s; e.op = op;
    return e;
  endfunction

  // Hold reset over two edges, release 1 time unit after an edge: state RESET.
  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.instr = 16'h0000;
    bus.alu_n = 1'b0; bus.alu_z = 1'b0; bus.alu_c = 1'b0;
    reset = 1'b1;
    step();
    checks++;
    if (outs() !== 21'd0) begin
      errors++;
      $display("FAIL reset_outs: actual=%h required=0", outs());
    end
    reset = 1'b0;
    #1;
    checks++;
    if (outs() !== 21'd0) begin
      errors++;
      $display("FAIL reset_state_after_release: actual=%h required=0", outs());
    end
    step();
    checks++;
    if ({bus.ir_ld, bus.pc_inc, bus.w_en} !== 3'b110) begin
      errors++;
      $display("FAIL first_fetch: actual=%b required=110", {bus.ir_ld, bus.pc_inc, bus.w_en});
    end
    $display("reset done");
  endtask

  // Entered in FETCH.
  task automatic test_add();
    bus.instr = 16'h0299;
    exp_q.push_back(mkwb(3'd2, 3'd3, 3'd1, 4'd1));
    step(); // DECODE
    checks++;
    if ({bus.pc_inc, bus.ir_ld, bus.w_en, bus.w_adr, bus.r_adr, bus.s_adr, bus.alu_op}
        !== {3'b000, 3'd2, 3'd3, 3'd1, 4'd0}) begin
      errors++;
      $display("FAIL add_decode: actual=%b required=%b",
               {bus.pc_inc, bus.ir_ld, bus.w_en, bus.w_adr, bus.r_adr, bus.s_adr, bus.alu_op},
               {3'b000, 3'd2, 3'd3, 3'd1, 4'd0});
    end
    bus.alu_n = 1'b0; bus.alu_z = 1'b1; bus.alu_c = 1'b0;
    step(); // EXECUTE
    checks++;
    if ({bus.w_en, bus.w_adr, bus.r_adr, bus.s_adr, bus.alu_op} !== {1'b1, 3'd2, 3'd3, 3'd1, 4'd1}) begin
      errors++;
      $display("FAIL add_execute: actual=%b required=%b",
               {bus.w_en, bus.w_adr, bus.r_adr, bus.s_adr, bus.alu_op},
               {1'b1, 3'd2, 3'd3, 3'd1, 4'd1});
    end
    step(); // FETCH
    checks++;
    if ({bus.ir_ld, bus.pc_inc, bus.w_en, bus.flags} !== {3'b110, 3'b010}) begin
      errors++;
      $display("FAIL add_next_fetch: actual=%b required=110010",
               {bus.ir_ld, bus.pc_inc, bus.w_en, bus.flags});
    end
    $display("add W2,R3,S1 done");
  endtask

  // Entered in FETCH.
  task automatic test_sub_nop();
    bus.instr = mk(7'h02, 3'd4, 3'd5, 3'd6);
    exp_q.push_back(mkwb(3'd4, 3'd5, 3'd6, 4'd2));
    step(); // DECODE
    checks++;
    if (bus.flags !== 3'b010) begin
      errors++;
      $display("FAIL flags_hold_decode: actual=%b required=010", bus.flags);
    end
    bus.alu_n = 1'b1; bus.alu_z = 1'b0; bus.alu_c = 1'b1;
    step(); // EXECUTE
    checks++;
    if ({bus.w_en, bus.alu_op} !== {1'b1, 4'd2}) begin
      errors++;
      $display("FAIL sub_execute: actual=%b required=10010", {bus.w_en, bus.alu_op});
    end
    step(); // FETCH
    checks++;
    if (bus.flags !== 3'b101) begin
      errors++;
      $display("FAIL sub_flags: actual=%b required=101", bus.flags);
    end
    bus.instr = mk(7'h00, 3'd3, 3'd3, 3'd3);
    bus.alu_n = 1'b0; bus.alu_z = 1'b1; bus.alu_c = 1'b0;
    step(); // DECODE of NOP
    checks++;
    if ({bus.w_en, bus.ir_ld, bus.alu_op} !== 6'b0) begin
      errors++;
      $display("FAIL nop_decode: actual=%b required=000000", {bus.w_en, bus.ir_ld, bus.alu_op});
    end
    step(); // back to FETCH after 2 cycles
    checks++;
    if ({bus.ir_ld, bus.pc_inc, bus.w_en, bus.flags} !== {3'b110, 3'b101}) begin
      errors++;
      $display("FAIL nop_two_cycles: actual=%b required=110101",
               {bus.ir_ld, bus.pc_inc, bus.w_en, bus.flags});
    end
    $display("sub then nop done");
  endtask

  // Entered in FETCH.
  task automatic test_halt();
    logic bad;
    bus.instr = 16'hFE00;
    step(); // DECODE
    checks++;
    if (bus.halted !== 1'b0) begin
      errors++;
      $display("FAIL halt_early: actual=%b required=0", bus.halted);
    end
    bus.instr = 16'h0299;
    step(); // HALT
    checks++;
    if ({bus.halted, bus.illegal, bus.flags} !== {2'b10, 3'b101}) begin
      errors++;
      $display("FAIL halt_state: actual=%b required=10101", {bus.halted, bus.illegal, bus.flags});
    end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.pc_inc !== 1'b0 || bus.w_en !== 1'b0 || bus.halted !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL halt_absorbing: actual=activity after halt required=none");
    end
    $display("halt done");
  endtask

  task automatic test_illegal();
    logic bad;
    do_reset();
    step(); // FETCH
    bus.instr = mk(7'h20, 3'd1, 3'd2, 3'd3);
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.w_en !== 1'b0) bad = 1'b1;
    end
    checks++;
    if ({bus.halted, bus.illegal, bad} !== 3'b110) begin
      errors++;
      $display("FAIL illegal_halt: actual=%b required=110", {bus.halted, bus.illegal, bad});
    end
    $display("illegal opcode 0x20 done");
  endtask

  task automatic test_async_reset();
    do_reset();
    step(); // FETCH
    bus.instr = mk(7'h01, 3'd7, 3'd2, 3'd5);
    step(); // DECODE
    bus.alu_n = 1'b1; bus.alu_z = 1'b1; bus.alu_c = 1'b1;
    step(); // EXECUTE, 1 unit after the edge
    checks++;
    if ({bus.w_en, bus.w_adr} !== {1'b1, 3'd7}) begin
      errors++;
      $display("FAIL pre_reset_execute: actual=%b required=1111", {bus.w_en, bus.w_adr});
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (outs() !== 21'd0) begin
      errors++;
      $display("FAIL async_reset_outs: actual=%h required=0", outs());
    end
    step();
    reset = 1'b0;
    step(); // FETCH
    checks++;
    if ({bus.ir_ld, bus.pc_inc, bus.w_en, bus.w_adr, bus.flags} !== {3'b110, 3'd0, 3'd0}) begin
      errors++;
      $display("FAIL restart_fetch: actual=%b required=110000000",
               {bus.ir_ld, bus.pc_inc, bus.w_en, bus.w_adr, bus.flags});
    end
    $display("async reset mid-execute done");
  endtask

  // Entered in FETCH.
  task automatic test_back_to_back();
    int pulses;
    int first_at;
    int second_at;
    pulses = 0; first_at = -1; second_at = -1;
    bus.instr = mk(7'h08, 3'd0, 3'd1, 3'd2);
    exp_q.push_back(mkwb(3'd0, 3'd1, 3'd2, 4'd8));
    exp_q.push_back(mkwb(3'd7, 3'd3, 3'd4, 4'd9));
    for (int i = 1; i <= 6; i++) begin
      step();
      if (bus.ir_ld === 1'b1) bus.instr = mk(7'h09, 3'd7, 3'd3, 3'd4);
      if (bus.w_en === 1'b1) begin
        pulses++;
        if (first_at < 0) first_at = i;
        else second_at = i;
      end
    end
    checks++;
    if (pulses != 2 || first_at != 2 || second_at - first_at != 3) begin
      errors++;
      $display("FAIL b2b_pulses: actual=%0d pulses at %0d,%0d required=2 pulses at 2,5",
               pulses, first_at, second_at);
    end
    $display("inc W0 / dec W7 back-to-back done");
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_nop();
    test_halt();
    test_illegal();
    test_async_reset();
    test_back_to_back();
    step();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL wb_missing: actual=%0d pending required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_control_unit.md
# cpu_control_unit

Multi-cycle control unit for the 16-bit RISC CPU execution unit. It fetches a 16-bit instruction, holds it in an internal instruction register, and sequences FETCH/DECODE/EXECUTE. It drives register-file addresses, ALU operation select and the register write enable. The write enable and W address feed the 3-to-8 register write decoder directly as its enable and select inputs.

## Interface
- No parameters; widths fixed by the ISA (16-bit instruction, 8 registers).
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high; clears all state
- instr  in  16  instruction word from memory at current PC
- alu_n, alu_z, alu_c  in  1 each  ALU status (negative, zero, carry) for the current operation
- pc_inc  out  1  advance PC (one cycle per FETCH)
- ir_ld  out  1  instruction register load strobe (FETCH)
- w_en  out  1  register write enable; drives decoder enable
- w_adr, r_adr, s_adr  out  3 each  write, R-read and S-read register addresses
- alu_op  out  4  ALU function select
- flags  out  3  latched {N,Z,C}
- halted  out  1  in HALT state
- illegal  out  1  halted due to undefined opcode

## Operation
- Format: [15:9] opcode, [8:6] W, [5:3] R, [2:0] S.
- Opcodes: 00 NOP, 01 ADD, 02 SUB, 03 AND, 04 OR, 05 XOR, 06 NOT, 07 MOV, 08 INC, 09 DEC, 7F HALT. Any other value is illegal.
- ALU ops are 01–09. For these, alu_op = opcode[3:0].
- States: RESET -> FETCH -> DECODE -> EXECUTE -> FETCH.
- DECODE goes to HALT on HALT or on an illegal opcode. It goes to FETCH on NOP, skipping EXECUTE.
- HALT is absorbing; only reset leaves it.
- FETCH: ir_ld=1, pc_inc=1. The IR captures instr at the end of FETCH.
- DECODE: no strobes. w_adr, r_adr and s_adr are valid from the IR.
- EXECUTE (ALU ops only): w_en=1 for exactly one cycle. flags <= {alu_n, alu_z, alu_c} at the end of EXECUTE.
- r_adr, s_adr, w_adr and alu_op reflect the IR in all states except RESET, where they are 0.
- alu_op=0 outside EXECUTE.
- Outputs are Moore: decoded only from the state register and the IR, with no combinational path from any input.
- illegal is set in the DECODE→HALT transition for an undefined opcode. It stays 0 for a HALT opcode.

## Timing
- Reset values: state=RESET, IR=0, flags=0, and every output 0.
- The first FETCH is one cycle after reset deasserts.
- Cycles per instruction: ALU op 3, NOP 2. HALT is reached 2 cycles after its FETCH.
- w_en is high only in EXECUTE, never in two consecutive cycles, and never in FETCH/DECODE/HALT.
- Reset asserted mid-instruction: w_en and all strobes drop immediately, with no clock needed. The IR and flags clear, and the interrupted instruction is not written back.
- Flags update only on the EXECUTE clock edge. NOP and HALT leave flags unchanged.

## Structure
- Shared package cpu_pkg contains:
  - opcode constants
  - state encoding (RESET, FETCH, DECODE, EXECUTE, HALT; 3-bit)
  - IR field bit positions
  - alu_op width
- One sub-module: ir_reg16, a 16-bit load-enable register with async active-high reset. It is used for the IR.
- The FSM and output decode live in cpu_control_unit.

## Test plan
- Reset release, then instr=16'h0299 (ADD W2,R3,S1):
  - FETCH: ir_ld=pc_inc=1.
  - EXECUTE: w_en=1, w_adr=2, r_adr=3, s_adr=1, alu_op=1.
  - Next cycle: FETCH.
- SUB then NOP with alu_{n,z,c}=1,0,1 during SUB EXECUTE:
  - flags=3'b101 after SUB.
  - NOP takes 2 cycles with w_en=0 and flags unchanged.
- instr=16'hFE00 (HALT): halted=1 two cycles after its FETCH, illegal=0, and no further pc_inc for 10 cycles.
- instr opcode 7'h20: halted=1, illegal=1, w_en never asserted.
- Assert reset asynchronously mid-EXECUTE of ADD W7:
  - w_en falls before the next clock edge.
  - All outputs are 0.
  - After release the FSM restarts at FETCH.
- Back-to-back INC W0 and DEC W7: w_en pulses exactly once per instruction, 3 cycles apart, with w_adr 0 then 7.
